// File: rtl/dma_utils_pkg.sv
// dma_utils_pkg: shared FSM state type and address-boundary constant for DMA blocks
package dma_utils_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_CALC, ST_ISSUE, ST_DRAIN, ST_DONE} dma_bst_st_t;
  localparam int unsigned BOUND_4K = 4096;
endpackage

// File: rtl/dma_outst_cnt.sv
// dma_outst_cnt: bursts-in-flight counter; completions at zero are ignored
module dma_outst_cnt #(
  parameter int MAX = 8,
  parameter int CW = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else count <= count + CW'(inc) - CW'(dec && count != '0);
  assign full = count == CW'(MAX);
endmodule

// File: rtl/dma_burst_sched.sv
// dma_burst_sched: splits a descriptor into AXI bursts bounded by MAX_BEATS and 4 KB pages
module dma_burst_sched import dma_utils_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int BPB = 4,
  parameter int MAX_BEATS = 256,
  parameter int MAX_OUTST = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           str_valid_i,
  input  logic [ADDR_W-1:0]              str_addr_i,
  input  logic [31:0]                    str_bytes_i,
  input  logic                           abort_i,
  output logic                           str_done_o,
  output logic                           bst_valid_o,
  input  logic                           bst_ready_i,
  output logic [ADDR_W-1:0]              bst_addr_o,
  output logic [7:0]                     bst_len_o,
  output logic [2:0]                     bst_size_o,
  input  logic                           bst_cmpl_i,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
  output logic                           busy_o
);
  localparam int SH = $clog2(BPB);
  localparam int CW = $clog2(MAX_OUTST + 1);
  dma_bst_st_t st;
  logic [ADDR_W-1:0] addr;
  logic [32:0] left, room_b, cap, nlen, left_nxt;
  logic [12:0] room;
  logic [8:0] beats;
  logic [7:0] lm1;
  logic abt, post_done, hs, full, drain_ok;
  dma_outst_cnt #(.MAX(MAX_OUTST), .CW(CW)) u_cnt (
    .clk(clk), .rst(rst), .inc(hs), .dec(bst_cmpl_i), .count(outst_o), .full(full)
  );
  assign hs = bst_valid_o && bst_ready_i;
  assign room = 13'(BOUND_4K) - {1'b0, addr[11:0]};
  assign drain_ok = outst_o == '0 || (outst_o == CW'(1) && bst_cmpl_i);
  always_comb begin
    room_b = 33'(room >> SH);
    cap = room_b < 33'(MAX_BEATS) ? room_b : 33'(MAX_BEATS);
    nlen = left < cap ? left : cap;
    beats = {1'b0, lm1} + 9'd1;
    left_nxt = left - 33'(beats);
  end
  // lm1 holds beats-minus-one so that the reset value drives bst_len_o to zero
  always_ff @(posedge clk)
    if (rst) begin
      st <= ST_IDLE;
      addr <= '0;
      left <= '0;
      lm1 <= '0;
      abt <= 1'b0;
      post_done <= 1'b0;
    end else begin
      post_done <= st == ST_DONE;
      if (st != ST_IDLE && abort_i) abt <= 1'b1;
      case (st)
        ST_IDLE: if (str_valid_i && !post_done) begin
          addr <= str_addr_i;
          left <= ({1'b0, str_bytes_i} + 33'(BPB - 1)) >> SH;
          st <= ST_CALC;
        end
        ST_CALC: if (left == '0) st <= ST_DONE;
          else begin
            lm1 <= 8'(nlen - 33'd1);
            st <= ST_ISSUE;
          end
        ST_ISSUE: if (hs) begin
          addr <= addr + (ADDR_W'(beats) << SH);
          left <= left_nxt;
          st <= (left_nxt != '0 && !abt && !abort_i) ? ST_CALC : ST_DRAIN;
        end
        ST_DRAIN: if (drain_ok) st <= ST_DONE;
        ST_DONE: begin
          abt <= 1'b0;
          st <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  assign bst_valid_o = st == ST_ISSUE && !full;
  assign bst_addr_o = addr;
  assign bst_len_o = lm1;
  assign bst_size_o = 3'(SH);
  assign str_done_o = st == ST_DONE;
  assign busy_o = st != ST_IDLE;
endmodule

// File: tb/tb_dma_burst_sched.sv
// tb_dma_burst_sched: table-driven and directed checks of burst splitting, flow control and abort
module tb_dma_burst_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic str_valid_i = 0, abort_i = 0, bst_ready_i = 0, bst_cmpl_i = 0;
  logic [31:0] str_addr_i = 0, str_bytes_i = 0;
  logic str_done_o, bst_valid_o, busy_o;
  logic [31:0] bst_addr_o;
  logic [7:0] bst_len_o;
  logic [2:0] bst_size_o;
  logic [1:0] outst_o;
  always #5 clk = ~clk;

  dma_burst_sched #(.ADDR_W(32), .BPB(4), .MAX_BEATS(256), .MAX_OUTST(2)) dut (
    .clk(clk), .rst(rst), .str_valid_i(str_valid_i), .str_addr_i(str_addr_i),
    .str_bytes_i(str_bytes_i), .abort_i(abort_i), .str_done_o(str_done_o),
    .bst_valid_o(bst_valid_o), .bst_ready_i(bst_ready_i), .bst_addr_o(bst_addr_o),
    .bst_len_o(bst_len_o), .bst_size_o(bst_size_o), .bst_cmpl_i(bst_cmpl_i),
    .outst_o(outst_o), .busy_o(busy_o)
  );

  int checks = 0, passed = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  logic [31:0] ga[8];
  logic [7:0] gl[8];
  int nb, t_valid, t_done, t_cmpl;

  // Acts as the burst target: accepts every request and completes each burst one cycle later
  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit hold, input bit abt);
    int pend = 0, t = 0;
    bit same = 0, ab_done = 0;
    logic [1:0] oc = 0;
    nb = 0; t_valid = -1; t_done = -1; t_cmpl = -1;
    str_addr_i = a; str_bytes_i = b; str_valid_i = 1; bst_ready_i = 1;
    while (t_done < 0 && t < 3000) begin
      @(negedge clk);
      t++;
      if (same) chk("outst_hs_and_cmpl", outst_o, oc);
      same = 0;
      if (hold && t == 20) begin
        chk("hold_handshakes", nb, 2);
        chk("hold_valid_low", bst_valid_o, 0);
        chk("hold_outst", outst_o, 2);
      end
      if (str_done_o) begin
        t_done = t;
        str_valid_i = 0;
      end
      bst_cmpl_i = pend > 0 && (!hold || t >= 30);
      if (bst_cmpl_i) begin
        pend--;
        t_cmpl = t;
      end
      abort_i = abt && nb == 1 && !ab_done;
      if (abort_i) ab_done = 1;
      if (bst_valid_o) begin
        if (t_valid < 0) t_valid = t;
        if (nb < 8) begin
          ga[nb] = bst_addr_o;
          gl[nb] = bst_len_o;
        end
        nb++;
        pend++;
        same = bst_cmpl_i;
        oc = outst_o;
      end
    end
    if (t_done < 0) chk("done_timeout", 0, 1);
    @(negedge clk);
    bst_cmpl_i = 0;
    abort_i = 0;
    chk("done_one_cycle", str_done_o, 0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] a, b;
    int n;
    logic [31:0] a0, a1;
    logic [7:0] l0, l1;
  } vec_t;
  vec_t vt[7];

  initial begin
    vt[0] = '{32'h1000, 64, 1, 32'h1000, 0, 15, 0};
    vt[1] = '{32'h0FF0, 64, 2, 32'h0FF0, 32'h1000, 3, 11};
    vt[2] = '{32'h0000, 2048, 2, 32'h0000, 32'h0400, 255, 255};
    vt[3] = '{32'h0FFC, 5, 2, 32'h0FFC, 32'h1000, 0, 0};
    vt[4] = '{32'h0000, 0, 0, 0, 0, 0, 0};
    vt[5] = '{32'hFFFF_FFF8, 16, 2, 32'hFFFF_FFF8, 32'h0000_0000, 1, 1};
    vt[6] = '{32'h2000, 1, 1, 32'h2000, 0, 0, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", str_done_o, 0);
    chk("rst_valid", bst_valid_o, 0);
    chk("rst_addr", bst_addr_o, 0);
    chk("rst_len", bst_len_o, 0);
    chk("rst_size", bst_size_o, 2);
    chk("rst_outst", outst_o, 0);
    chk("rst_busy", busy_o, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      run(vt[i].a, vt[i].b, 0, 0);
      chk($sformatf("v%0d_bursts", i), nb, vt[i].n);
      if (vt[i].n == 0) chk($sformatf("v%0d_done_t", i), t_done, 2);
      else begin
        chk($sformatf("v%0d_latency", i), t_valid, 2);
        chk($sformatf("v%0d_done_after_cmpl", i), t_done, t_cmpl + 1);
        chk($sformatf("v%0d_addr0", i), ga[0], vt[i].a0);
        chk($sformatf("v%0d_len0", i), gl[0], vt[i].l0);
      end
      if (vt[i].n > 1) begin
        chk($sformatf("v%0d_addr1", i), ga[1], vt[i].a1);
        chk($sformatf("v%0d_len1", i), gl[1], vt[i].l1);
      end
    end
    run(32'h0, 4096, 1, 0);
    chk("hold_total", nb, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold_addr%0d", k), ga[k], k * 32'h400);
      chk($sformatf("hold_len%0d", k), gl[k], 255);
    end
    chk("hold_done_after_cmpl", t_done, t_cmpl + 1);
    run(32'h0, 4096, 0, 1);
    chk("abort_bursts", nb, 2);
    chk("abort_addr1", ga[1], 32'h400);
    chk("abort_done_after_cmpl", t_done, t_cmpl + 1);
    chk("abort_outst_end", outst_o, 0);
    str_addr_i = 0; str_bytes_i = 0; str_valid_i = 1;
    while (!str_done_o) @(negedge clk);
    @(negedge clk);
    chk("post_done_idle", busy_o, 0);
    @(negedge clk);
    chk("post_done_reject", busy_o, 0);
    @(negedge clk);
    chk("post_done_accept", busy_o, 1);
    str_valid_i = 0;
    repeat (3) @(negedge clk);
    str_addr_i = 0; str_bytes_i = 4096; str_valid_i = 1; bst_ready_i = 1;
    repeat (2) @(negedge clk);
    chk("mid_valid", bst_valid_o, 1);
    @(negedge clk);
    bst_ready_i = 0;
    @(negedge clk);
    chk("mid_outst", outst_o, 1);
    rst = 1; str_valid_i = 0;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_outst", outst_o, 0);
    chk("mid_rst_valid", bst_valid_o, 0);
    chk("mid_rst_addr", bst_addr_o, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mid_rst_no_done", str_done_o, 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
